// File: rtl/sdcard_block_loader.sv
// rtl/sdcard_block_loader.sv - streams raw SD blocks into a word-addressed RAM write port
// Jobs are started at run time; each job reads whole blocks and drains the tail of the last one.
module sdcard_block_loader #(
    parameter int               DATA_W     = 16,
    parameter int               ADDR_W     = 25,
    parameter int               CNT_W      = 25,
    parameter int               SDHC       = 1,
    parameter int               BIG_ENDIAN = 1,
    parameter int               AUTO_START = 0,
    parameter logic [31:0]      DEF_BLOCK  = 32'd0,
    parameter logic [CNT_W-1:0] DEF_COUNT  = 25'h71AFE0
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       start_block,
    input  logic [ADDR_W-1:0] ram_base,
    input  logic [CNT_W-1:0]  word_count,
    output logic              sd_rd,
    output logic              sd_continue,
    output logic [31:0]       sd_addr,
    input  logic              sd_busy,
    input  logic              sd_data_rdy,
    output logic              sd_data_next,
    input  logic [7:0]        sd_data,
    input  logic [15:0]       sd_error,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    input  logic              ram_op_begun,
    output logic              busy,
    output logic              ram_init_done,
    output logic              ram_init_error,
    output logic [CNT_W-1:0]  progress
);

    localparam int         BYTES    = DATA_W / 8;
    localparam logic [1:0] LAST_IDX = 2'(BYTES - 1);

    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_IDLE,
        S_READBLOCK,
        S_BYTE_WAIT,
        S_BYTE_ACK,
        S_WRITE,
        S_DRAIN,
        S_DRAIN_ACK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state, state_n;
    logic [31:0]        blk;
    logic [ADDR_W-1:0]  addr;
    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   progress_q;
    logic               first;
    logic [1:0]         idx;
    logic [1:0]         lane;
    logic [DATA_W-1:0]  word_q;

    assign lane = (BIG_ENDIAN != 0) ? LAST_IDX - idx : idx;

    always_ff @(posedge clk50) begin
        if (reset) begin
            state <= S_INIT_WAIT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_INIT_WAIT: begin
                if (!sd_busy) begin
                    if (sd_error != 16'd0) begin
                        state_n = S_ERROR;
                    end else if (AUTO_START != 0) begin
                        state_n = (DEF_COUNT == '0) ? S_DONE : S_READBLOCK;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = (word_count == '0) ? S_DONE : S_READBLOCK;
                end
            end
            S_READBLOCK: begin
                if (sd_busy) state_n = S_BYTE_WAIT;
            end
            S_BYTE_WAIT: begin
                if (!sd_busy)         state_n = S_READBLOCK;
                else if (sd_data_rdy) state_n = S_BYTE_ACK;
            end
            S_BYTE_ACK: begin
                if (!sd_data_rdy) state_n = (idx == LAST_IDX) ? S_WRITE : S_BYTE_WAIT;
            end
            S_WRITE: begin
                if (ram_op_begun) state_n = (remaining == CNT_W'(1)) ? S_DRAIN : S_BYTE_WAIT;
            end
            S_DRAIN: begin
                if (!sd_busy)         state_n = S_DONE;
                else if (sd_data_rdy) state_n = S_DRAIN_ACK;
            end
            S_DRAIN_ACK: begin
                if (!sd_data_rdy) state_n = S_DRAIN;
            end
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            blk        <= '0;
            addr       <= '0;
            remaining  <= '0;
            progress_q <= '0;
            first      <= 1'b0;
            idx        <= '0;
            word_q     <= '0;
        end else begin
            case (state)
                S_INIT_WAIT: begin
                    if (!sd_busy && sd_error == 16'd0 && AUTO_START != 0) begin
                        blk        <= DEF_BLOCK;
                        addr       <= '0;
                        remaining  <= DEF_COUNT;
                        progress_q <= '0;
                        first      <= 1'b1;
                    end
                end
                S_IDLE, S_DONE: begin
                    if (start) begin
                        blk        <= start_block;
                        addr       <= ram_base;
                        remaining  <= word_count;
                        progress_q <= '0;
                        first      <= 1'b1;
                    end
                end
                S_READBLOCK: begin
                    if (sd_busy) begin
                        first <= 1'b0;
                        idx   <= '0;
                    end
                end
                S_BYTE_WAIT: begin
                    if (!sd_busy) begin
                        blk <= blk + 32'd1;
                    end else if (sd_data_rdy) begin
                        for (int i = 0; i < BYTES; i++) begin
                            if (lane == 2'(i)) word_q[i*8 +: 8] <= sd_data;
                        end
                    end
                end
                S_BYTE_ACK: begin
                    // Index wraps after the last lane so the next word starts at byte 0.
                    if (!sd_data_rdy) idx <= (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
                end
                S_WRITE: begin
                    if (ram_op_begun) begin
                        addr       <= addr + ADDR_W'(1);
                        progress_q <= progress_q + CNT_W'(1);
                        remaining  <= remaining - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sd_rd          = (state == S_READBLOCK);
    assign sd_continue    = (state == S_READBLOCK) && !first;
    assign sd_addr        = (SDHC != 0) ? blk : {blk[22:0], 9'd0};
    assign sd_data_next   = (state == S_BYTE_ACK) || (state == S_DRAIN_ACK);
    assign ram_we         = (state == S_WRITE);
    assign ram_address    = addr;
    assign ram_data       = word_q;
    assign busy           = state inside {S_READBLOCK, S_BYTE_WAIT, S_BYTE_ACK, S_WRITE, S_DRAIN, S_DRAIN_ACK};
    assign ram_init_done  = (state == S_DONE);
    assign ram_init_error = (state == S_ERROR);
    assign progress       = progress_q;

endmodule

// File: tb/tb_sdcard_block_loader.sv
// tb/tb_sdcard_block_loader.sv - randomized bench for sdcard_block_loader against a card/RAM model
// Two instances (16-bit BE SDHC, 32-bit LE byte-addressed) share stimulus; sel picks the one observed.
module tb_sdcard_block_loader;

    logic        clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    logic        reset, start;
    logic [31:0] start_block;
    logic [24:0] ram_base, word_count;
    logic        sd_busy, sd_data_rdy, ram_op_begun;
    logic [7:0]  sd_data;
    logic [15:0] sd_error;

    logic        a_rd, a_cont, a_next, a_we, a_busy, a_done, a_err;
    logic [31:0] a_addr;
    logic [24:0] a_raddr, a_prog;
    logic [15:0] a_rdata;
    logic        b_rd, b_cont, b_next, b_we, b_busy, b_done, b_err;
    logic [31:0] b_addr;
    logic [24:0] b_raddr, b_prog;
    logic [31:0] b_rdata;

    sdcard_block_loader #(.DATA_W(16), .SDHC(1), .BIG_ENDIAN(1)) dut_a (
        .clk50(clk50), .reset(reset), .start(start), .start_block(start_block),
        .ram_base(ram_base), .word_count(word_count), .sd_rd(a_rd), .sd_continue(a_cont),
        .sd_addr(a_addr), .sd_busy(sd_busy), .sd_data_rdy(sd_data_rdy), .sd_data_next(a_next),
        .sd_data(sd_data), .sd_error(sd_error), .ram_we(a_we), .ram_address(a_raddr),
        .ram_data(a_rdata), .ram_op_begun(ram_op_begun), .busy(a_busy),
        .ram_init_done(a_done), .ram_init_error(a_err), .progress(a_prog));

    sdcard_block_loader #(.DATA_W(32), .SDHC(0), .BIG_ENDIAN(0)) dut_b (
        .clk50(clk50), .reset(reset), .start(start), .start_block(start_block),
        .ram_base(ram_base), .word_count(word_count), .sd_rd(b_rd), .sd_continue(b_cont),
        .sd_addr(b_addr), .sd_busy(sd_busy), .sd_data_rdy(sd_data_rdy), .sd_data_next(b_next),
        .sd_data(sd_data), .sd_error(sd_error), .ram_we(b_we), .ram_address(b_raddr),
        .ram_data(b_rdata), .ram_op_begun(ram_op_begun), .busy(b_busy),
        .ram_init_done(b_done), .ram_init_error(b_err), .progress(b_prog));

    logic        sel;
    logic        m_rd, m_cont, m_next, m_we, m_busy, m_done, m_err;
    logic [31:0] m_addr, m_rdata;
    logic [24:0] m_raddr, m_prog;
    assign m_rd    = sel ? b_rd    : a_rd;
    assign m_cont  = sel ? b_cont  : a_cont;
    assign m_next  = sel ? b_next  : a_next;
    assign m_we    = sel ? b_we    : a_we;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_err   = sel ? b_err   : a_err;
    assign m_addr  = sel ? b_addr  : a_addr;
    assign m_rdata = sel ? b_rdata : {16'h0, a_rdata};
    assign m_raddr = sel ? b_raddr : a_raddr;
    assign m_prog  = sel ? b_prog  : a_prog;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Card image and job model
    bit          pattern_mode;
    logic [7:0]  seed_a, seed_b;
    int unsigned job_blk, job_base, job_cnt;
    int          wr_count, rd_count, stall_at;
    bit          no_write, ctl_restart, init_go;

    function automatic int unsigned bytes_n();
        return sel ? 4 : 2;
    endfunction

    function automatic int unsigned wpb();
        return 512 / bytes_n();
    endfunction

    function automatic logic [7:0] card_byte(input int unsigned b, input int unsigned o);
        if (pattern_mode) return 8'(o + 1);
        return 8'(b * seed_a + o * 7) ^ seed_b ^ 8'(o >> 5);
    endfunction

    function automatic logic [31:0] exp_word(input int unsigned k);
        int unsigned b = job_blk + k / wpb();
        int unsigned o = (k % wpb()) * bytes_n();
        logic [31:0] w = 0;
        for (int j = 0; j < int'(bytes_n()); j++) begin
            if (!sel) w = (w << 8) | 32'(card_byte(b, o + j));
            else      w = w | (32'(card_byte(b, o + j)) << (8 * j));
        end
        return w;
    endfunction

    function automatic int unsigned nblocks(input int unsigned cnt);
        return (cnt + wpb() - 1) / wpb();
    endfunction

    // SD controller model
    int          ctl_st, ctl_gap, ctl_off;
    int unsigned ctl_blk;
    initial begin
        ctl_st = 6; sd_busy = 1'b1; sd_data_rdy = 1'b0; sd_data = 8'h0;
        forever begin
            @(negedge clk50);
            if (ctl_restart) begin
                ctl_st = 6; sd_busy = 1'b1; sd_data_rdy = 1'b0;
            end else begin
                case (ctl_st)
                    6: if (init_go) begin sd_busy = 1'b0; ctl_st = 0; end
                    0: if (m_rd) begin
                        check("rd_addr", m_addr, sel ? (job_blk + rd_count) << 9 : job_blk + rd_count);
                        check("rd_continue", {31'd0, m_cont}, {31'd0, rd_count > 0});
                        check("rd_in_range", 32'(rd_count < int'(nblocks(job_cnt))), 32'd1);
                        ctl_blk = sel ? m_addr >> 9 : m_addr;
                        rd_count++;
                        ctl_gap = $urandom_range(0, 2);
                        ctl_st = 1;
                    end
                    1: if (ctl_gap == 0) begin
                        sd_busy = 1'b1; ctl_off = 0; ctl_gap = $urandom_range(0, 1); ctl_st = 2;
                    end else ctl_gap--;
                    2: if (ctl_gap == 0) begin
                        sd_data = card_byte(ctl_blk, ctl_off); sd_data_rdy = 1'b1; ctl_st = 3;
                    end else ctl_gap--;
                    3: if (m_next) begin sd_data_rdy = 1'b0; ctl_st = 4; end
                    4: if (!m_next) begin
                        ctl_off++;
                        if (ctl_off == 512) begin sd_busy = 1'b0; ctl_st = 5; end
                        else begin ctl_gap = $urandom_range(0, 1); ctl_st = 2; end
                    end
                    default: ctl_st = 0;
                endcase
            end
        end
    end

    // RAM model with random accept latency
    bit          ram_inw;
    int          ram_stall;
    logic [31:0] hold_a, hold_d;
    initial begin
        ram_op_begun = 1'b0; ram_inw = 1'b0; ram_stall = 0;
        forever begin
            @(negedge clk50);
            ram_op_begun = 1'b0;
            if (m_we && !reset) begin
                if (!ram_inw) begin
                    ram_inw = 1'b1;
                    hold_a = 32'(m_raddr); hold_d = m_rdata;
                    ram_stall = (wr_count == stall_at) ? 7 : $urandom_range(0, 2);
                    if (no_write) check("we_after_reset", {31'd0, m_we}, 32'd0);
                    check("wr_addr", 32'(m_raddr), 32'(25'(job_base + wr_count)));
                    check("wr_data", m_rdata, exp_word(wr_count));
                end else begin
                    check("stall_addr", 32'(m_raddr), hold_a);
                    check("stall_data", m_rdata, hold_d);
                end
                if (ram_stall == 0) begin ram_op_begun = 1'b1; wr_count++; end
                else ram_stall--;
            end else begin
                ram_inw = 1'b0;
            end
        end
    end

    task automatic do_reset(input logic [15:0] err);
        reset = 1'b1; ctl_restart = 1'b1; init_go = 1'b0; sd_error = err; start = 1'b0;
        repeat (2) @(negedge clk50);
        check("rst_sd_rd", {31'd0, m_rd}, 32'd0);
        check("rst_sd_continue", {31'd0, m_cont}, 32'd0);
        check("rst_sd_addr", m_addr, 32'd0);
        check("rst_sd_data_next", {31'd0, m_next}, 32'd0);
        check("rst_ram_we", {31'd0, m_we}, 32'd0);
        check("rst_ram_address", 32'(m_raddr), 32'd0);
        check("rst_ram_data", m_rdata, 32'd0);
        check("rst_busy", {31'd0, m_busy}, 32'd0);
        check("rst_done", {31'd0, m_done}, 32'd0);
        check("rst_error", {31'd0, m_err}, 32'd0);
        check("rst_progress", 32'(m_prog), 32'd0);
        reset = 1'b0; ctl_restart = 1'b0;
        repeat (3) @(negedge clk50);
        init_go = 1'b1;
        repeat (3) @(negedge clk50);
        check("post_init_busy", {31'd0, m_busy}, 32'd0);
        check("post_init_done", {31'd0, m_done}, 32'd0);
    endtask

    task automatic run_job(input int unsigned blk, input int unsigned base, input int unsigned cnt,
                           input bit pmode, input int stall, input int poke_at, input int abort_at);
        int  t = 0;
        bit  poked = 1'b0;
        job_blk = blk; job_base = base; job_cnt = cnt; pattern_mode = pmode;
        seed_a = 8'($urandom); seed_b = 8'($urandom);
        wr_count = 0; rd_count = 0; stall_at = stall;
        @(negedge clk50);
        start_block = blk; ram_base = 25'(base); word_count = 25'(cnt); start = 1'b1;
        @(negedge clk50);
        start = 1'b0; start_block = $urandom; ram_base = 25'($urandom); word_count = 25'($urandom);
        while (!(m_done && !m_busy) && t < 20000) begin
            if (abort_at >= 0 && wr_count >= abort_at) return;
            if (poke_at >= 0 && !poked && wr_count >= poke_at) begin
                start_block = 32'd99; ram_base = 25'd0; word_count = 25'd1; start = 1'b1;
                @(negedge clk50);
                start = 1'b0; poked = 1'b1; t++;
            end else begin
                @(negedge clk50);
                t++;
            end
        end
        check("job_finished", 32'(t < 20000), 32'd1);
        if (cnt == 0) check("zero_count_latency", 32'(t), 32'd0);
        check("wr_count", 32'(wr_count), cnt);
        check("progress", 32'(m_prog), cnt);
        check("rd_count", 32'(rd_count), nblocks(cnt));
        check("done_flag", {31'd0, m_done}, 32'd1);
    endtask

    initial begin
        sel = 1'b0; reset = 1'b1; start = 1'b0; start_block = 0; ram_base = 0; word_count = 0;
        sd_error = 0; ctl_restart = 1'b1; init_go = 1'b0; no_write = 1'b0; stall_at = -1;
        job_blk = 0; job_base = 0; job_cnt = 0; wr_count = 0; rd_count = 0; pattern_mode = 1'b1;
        seed_a = 0; seed_b = 0;

        // Init failure is sticky and blocks jobs
        do_reset(16'h0002);
        check("init_error", {31'd0, m_err}, 32'd1);
        start_block = 1; word_count = 5; start = 1'b1;
        @(negedge clk50);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk50);
            check("err_no_sd_rd", {31'd0, m_rd}, 32'd0);
            check("err_sticky", {31'd0, m_err}, 32'd1);
        end
        check("err_rd_count", 32'(rd_count), 32'd0);

        do_reset(16'h0000);
        run_job(5, 32'h100, 3, 1'b1, 1, -1, -1);
        run_job($urandom_range(0, 1000), 0, 0, 1'b0, -1, -1, -1);
        run_job($urandom_range(0, 1000), $urandom_range(0, 4096), 20, 1'b0, -1, 5, -1);
        run_job($urandom, 25'h1FFFFFD, $urandom_range(250, 300), 1'b0, $urandom_range(0, 20), -1, -1);
        for (int i = 0; i < 2; i++)
            run_job($urandom, $urandom, $urandom_range(1, 300), 1'b0, $urandom_range(0, 200), -1, -1);

        // Reset during the 40th word
        run_job($urandom_range(0, 1000), $urandom_range(0, 4096), 300, 1'b0, -1, -1, 39);
        no_write = 1'b1;
        do_reset(16'h0000);
        repeat (10) @(negedge clk50);
        no_write = 1'b0;
        run_job($urandom_range(0, 1000), $urandom_range(0, 4096), 40, 1'b0, -1, -1, -1);

        // 32-bit little-endian byte-addressed instance
        sel = 1'b1;
        do_reset(16'h0000);
        run_job(2, 0, 130, 1'b0, 64, -1, -1);
        run_job($urandom_range(0, 100000), $urandom, $urandom_range(1, 200), 1'b0, -1, -1, -1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/sdcard_block_loader.md
Name: sdcard_block_loader

Overview:
Parametrised SD-card-to-RAM loader. It streams raw SD blocks into a word-addressed RAM, with configurable word width, byte order and addressing mode. Each job is started at run time with its own start block, RAM base and word count, so several assets can be loaded from one card without a reset. It sits between the SD controller handshake interface (the controller is instantiated by the wrapper) and the SDRAM/on-chip RAM write port.

Parameters:
DATA_W, 16, RAM word width in bits; must be 8, 16 or 32; BYTES = DATA_W/8.
ADDR_W, 25, RAM word-address width.
CNT_W, 25, width of word_count and progress.
SDHC, 1, 1: sd_addr is a block number; 0: sd_addr is a byte address (block*512).
BIG_ENDIAN, 1, 1: first SD byte of a word goes to the MS byte; 0: first byte goes to the LS byte.
AUTO_START, 0, 1: after init, run one job with the DEF_* values without needing start.
DEF_BLOCK, 0, start block for the auto job.
DEF_COUNT, 25'h71AFE0, word count for the auto job.

Ports:
clk50  in  1  clock
reset  in  1  synchronous, active-high; reset clk50
start  in  1  one-cycle pulse; accepted only in IDLE or DONE
start_block  in  32  first SD block of the job, sampled on start
ram_base  in  ADDR_W  first RAM word address, sampled on start
word_count  in  CNT_W  number of words to load, sampled on start
sd_rd  out  1  block read request to controller
sd_continue  out  1  continue flag to controller
sd_addr  out  32  block/byte address to controller
sd_busy  in  1  controller busy
sd_data_rdy  in  1  controller byte-valid handshake
sd_data_next  out  1  byte acknowledge to controller
sd_data  in  8  controller byte
sd_error  in  16  controller error code
ram_we  out  1  write request
ram_address  out  ADDR_W  write word address
ram_data  out  DATA_W  write data
ram_op_begun  in  1  RAM accepted the write
busy  out  1  job in progress
ram_init_done  out  1  last job completed
ram_init_error  out  1  controller init failed
progress  out  CNT_W  words written in current/last job

Behaviour:
- All outputs are registered or decoded from state. Reset values: every output 0, state INIT_WAIT. Reset mid-job abandons the job immediately with no further RAM writes.
- Derived constant: WPB = 512/BYTES words per block.
- INIT_WAIT:
  - sd_busy=0 and sd_error=0 -> IDLE (or LOAD when AUTO_START, which loads the DEF_* values with ram_base 0).
  - sd_busy=0 and sd_error!=0 -> ERROR.
- IDLE/DONE:
  - On start, latch blk=start_block, addr=ram_base, remaining=word_count; clear progress and ram_init_done; set first=1.
  - If word_count=0, go to DONE next cycle with no sd_rd.
  - Otherwise -> READBLOCK.
- READBLOCK:
  - sd_rd=1; sd_continue=!first.
  - sd_addr = blk (SDHC=1) or blk<<9 (SDHC=0), held stable.
  - On sd_busy=1: clear first, reset byte index and word-in-block counter, go to BYTE_WAIT.
- BYTE_WAIT:
  - sd_busy=0 (block ended) -> blk+1, READBLOCK.
  - sd_data_rdy=1 -> place sd_data in the lane given by the byte index and BIG_ENDIAN, go to BYTE_ACK.
- BYTE_ACK:
  - sd_data_next=1 until sd_data_rdy=0.
  - Then, if the last byte of the word was taken, go to WRITE; otherwise byte index+1, back to BYTE_WAIT.
- WRITE:
  - ram_we=1; ram_address and ram_data held until ram_op_begun=1 (RAM may stall any number of cycles).
  - On accept: addr+1 (wraps modulo 2^ADDR_W), progress+1, remaining-1, word-in-block+1.
  - If remaining becomes 0 -> DRAIN; else BYTE_WAIT.
- DRAIN:
  - Acknowledge and discard the remaining bytes of the current block with the same rdy/next handshake; no ram_we.
  - On sd_busy=0 -> DONE. If the block was already exhausted, DONE as soon as sd_busy=0.
- DONE: ram_init_done=1 and busy=0; a new start is accepted here.
- ERROR: ram_init_error=1, sticky; start ignored; only reset exits.
- busy=1 in every state from READBLOCK through DRAIN.
- start outside IDLE/DONE is ignored; the latched job parameters never change mid-job.
- Byte order example, DATA_W=32 and BIG_ENDIAN=1: bytes 11,22,33,44 produce word 0x11223344. With BIG_ENDIAN=0 the same bytes produce 0x44332211.

Test Plan:
- Init error: sd_busy falls with sd_error=16'h0002 -> ram_init_error=1 is sticky, start pulses ignored, no sd_rd; reset clears it.
- DATA_W=16, BIG_ENDIAN=1, start_block=5, ram_base=0x100, word_count=3 -> sd_addr=5, sd_continue=0, writes 0x0102@0x100, 0x0304@0x101, 0x0506@0x102. Remaining 506 bytes drained with no ram_we; then ram_init_done=1 and progress=3.
- DATA_W=32, BIG_ENDIAN=0, SDHC=0, start_block=2, word_count=130 (WPB=128) -> two blocks read. sd_addr=0x400 (continue=0), then 0x600 (continue=1); 128+2 writes, the second block drained after 2 words.
- RAM stall: ram_op_begun held low 7 cycles during WRITE -> ram_we, ram_address and ram_data stable for all 7 cycles; exactly one address increment on accept.
- Back-to-back jobs: a start in DONE with word_count=0 -> DONE within 1 cycle, no sd_rd, progress=0. A start during busy -> ignored, first job completes unchanged.
- Reset mid-block (during the 40th word): no further ram_we; outputs return to 0; the next job from IDLE is correct.
